ingreso_numero: RTL and testbench

- Sits directly downstream of the button debouncer and the keypad encoder.
- Turns each debounced key press into one action: append a decimal digit, clear the entry, or commit the entry.
- Accumulates up to DIG digits as BCD (for the 7-segment preview) and as binary.
- On commit, presents the number to the arithmetic stage through a valid/ready handshake.

---
 rtl/ingreso_pkg.sv | 10 +
 rtl/detector_flanco.sv | 21 ++
 rtl/ingreso_numero.sv | 118 +++++++++++
 tb/tb_ingreso_numero.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/ingreso_pkg.sv
// Shared definitions for the keypad number-entry block.
//   TECLA_BORRAR : key code that clears the current entry
//   TECLA_ENTER  : key code that commits the current entry
//   estado_t     : CAPTURA (collecting digits) / ENVIO (waiting for downstream)
package ingreso_pkg;
  localparam logic [3:0] TECLA_BORRAR = 4'hA;
  localparam logic [3:0] TECLA_ENTER  = 4'hB;

  typedef enum logic {CAPTURA, ENVIO} estado_t;
endpackage

// File: rtl/detector_flanco.sv
// Rising-edge detector for the debounced key level.
//   clk, rst_n : clock, async active-low reset
//   in         : level input, already synchronous to clk
//   pulso      : one-cycle high on a 0->1 transition of in
// The history flop resets to 1 so a key held across reset release is not
// seen as a press; it has to be released and pressed again.
module detector_flanco (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic pulso
);
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b1;
    else        prev_q <= in;
  end

  assign pulso = in & ~prev_q;
endmodule

// File: rtl/ingreso_numero.sv
// Keypad number entry: turns each key press into append-digit / clear /
// commit, accumulating up to DIG digits in BCD and binary, and hands the
// committed number downstream over valid/ready.
//   clk, rst_n      : clock, async active-low reset
//   boton_sal       : debounced key-pressed level
//   codigo          : key code, stable while boton_sal=1
//   num_ready       : downstream accepts the number
//   num_valid       : committed number available
//   num_bcd         : BCD digits, MSD in the top nibble
//   num_bin         : binary value of num_bcd
//   digitos         : digits currently entered
//   tecla_ignorada  : one-cycle pulse when a press is discarded
module ingreso_numero
  import ingreso_pkg::*;
#(
  parameter  int DIG   = 3,
  parameter  int BIN_W = 10,
  localparam int CNT_W = $clog2(DIG+1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               boton_sal,
  input  logic [3:0]         codigo,
  input  logic               num_ready,
  output logic               num_valid,
  output logic [4*DIG-1:0]   num_bcd,
  output logic [BIN_W-1:0]   num_bin,
  output logic [CNT_W-1:0]   digitos,
  output logic               tecla_ignorada
);
  estado_t            estado_q, estado_d;
  logic [4*DIG-1:0]   bcd_q, bcd_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               ign_q, ign_d;
  logic               pulsacion;
  logic               es_digito;

  detector_flanco u_flanco (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (boton_sal),
    .pulso (pulsacion)
  );

  assign es_digito = (codigo < 4'd10);

  always_comb begin
    estado_d = estado_q;
    bcd_d    = bcd_q;
    bin_d    = bin_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;
    ign_d    = 1'b0;
    unique case (estado_q)
      CAPTURA: begin
        if (pulsacion) begin
          if (es_digito) begin
            if (cnt_q < CNT_W'(DIG)) begin
              bcd_d = (bcd_q << 4) | (4*DIG)'(codigo);
              // Arithmetic mod 2^BIN_W; BIN_W is sized so no overflow occurs.
              bin_d = bin_q * BIN_W'(10) + BIN_W'(codigo);
              cnt_d = cnt_q + CNT_W'(1);
            end else begin
              ign_d = 1'b1;
            end
          end else if (codigo == TECLA_BORRAR) begin
            bcd_d = '0;
            bin_d = '0;
            cnt_d = '0;
          end else if (codigo == TECLA_ENTER && cnt_q != '0) begin
            estado_d = ENVIO;
            valid_d  = 1'b1;
          end else begin
            ign_d = 1'b1;
          end
        end
      end
      ENVIO: begin
        // Entry is frozen; any press here, even on the accepting edge, is dropped.
        if (pulsacion) ign_d = 1'b1;
        if (num_ready) begin
          estado_d = CAPTURA;
          valid_d  = 1'b0;
          bcd_d    = '0;
          bin_d    = '0;
          cnt_d    = '0;
        end
      end
      default: estado_d = CAPTURA;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= CAPTURA;
      bcd_q    <= '0;
      bin_q    <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      ign_q    <= 1'b0;
    end else begin
      estado_q <= estado_d;
      bcd_q    <= bcd_d;
      bin_q    <= bin_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      ign_q    <= ign_d;
    end
  end

  assign num_valid      = valid_q;
  assign num_bcd        = bcd_q;
  assign num_bin        = bin_q;
  assign digitos        = cnt_q;
  assign tecla_ignorada = ign_q;
endmodule

// File: tb/tb_ingreso_numero.sv
// Directed bench for ingreso_numero (DIG=3, BIN_W=10).
module tb_ingreso_numero;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        boton_sal = 1'b0;
  logic [3:0]  codigo = 4'h0;
  logic        num_ready = 1'b0;
  logic        num_valid;
  logic [11:0] num_bcd;
  logic [9:0]  num_bin;
  logic [1:0]  digitos;
  logic        tecla_ignorada;

  int errs = 0;
  int checks = 0;
  int ign_cnt = 0;
  int vld_cnt = 0;
  logic [11:0] cap_bcd = '0;
  logic [9:0]  cap_bin = '0;
  logic [1:0]  cap_dig = '0;
  int ign_base, vld_base;

  ingreso_numero #(.DIG(3), .BIN_W(10)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .boton_sal      (boton_sal),
    .codigo         (codigo),
    .num_ready      (num_ready),
    .num_valid      (num_valid),
    .num_bcd        (num_bcd),
    .num_bin        (num_bin),
    .digitos        (digitos),
    .tecla_ignorada (tecla_ignorada)
  );

  always #5 clk = ~clk;

  // Sample away from the active edge; count pulses / valid cycles and
  // capture what was presented while valid.
  always @(negedge clk) begin
    if (tecla_ignorada) ign_cnt++;
    if (num_valid) begin
      vld_cnt++;
      cap_bcd = num_bcd;
      cap_bin = num_bin;
      cap_dig = digitos;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] c);
    codigo = c;
    boton_sal = 1'b1;
    repeat (5) tick();
    boton_sal = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_valid", 32'(num_valid), 0);
    chk("rst_bcd",   32'(num_bcd), 0);
    chk("rst_bin",   32'(num_bin), 0);
    chk("rst_dig",   32'(digitos), 0);
    chk("rst_ign",   32'(tecla_ignorada), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // 1,2,3 then ENTER with ready high: one valid cycle, then cleared
    num_ready = 1'b1;
    vld_base = vld_cnt; ign_base = ign_cnt;
    press(4'd1); press(4'd2); press(4'd3);
    chk("t1_bcd", 32'(num_bcd), 32'h123);
    chk("t1_bin", 32'(num_bin), 123);
    chk("t1_dig", 32'(digitos), 3);
    press(4'hB);
    chk("t1_vld_cycles", 32'(vld_cnt - vld_base), 1);
    chk("t1_cap_bcd", 32'(cap_bcd), 32'h123);
    chk("t1_cap_bin", 32'(cap_bin), 123);
    chk("t1_cap_dig", 32'(cap_dig), 3);
    chk("t1_post_valid", 32'(num_valid), 0);
    chk("t1_post_bcd", 32'(num_bcd), 0);
    chk("t1_post_bin", 32'(num_bin), 0);
    chk("t1_post_dig", 32'(digitos), 0);
    chk("t1_ign", 32'(ign_cnt - ign_base), 0);

    // overflow digit, clear, ENTER on empty entry
    ign_base = ign_cnt; vld_base = vld_cnt;
    press(4'd4); press(4'd5); press(4'd6); press(4'd7);
    chk("t2_ign_full", 32'(ign_cnt - ign_base), 1);
    chk("t2_bcd", 32'(num_bcd), 32'h456);
    chk("t2_bin", 32'(num_bin), 456);
    press(4'hA);
    chk("t2_clr_bcd", 32'(num_bcd), 0);
    chk("t2_clr_dig", 32'(digitos), 0);
    chk("t2_clr_ign", 32'(ign_cnt - ign_base), 1);
    press(4'hA);
    chk("t2_clr_empty_ign", 32'(ign_cnt - ign_base), 1);
    press(4'hB);
    chk("t2_enter_empty_ign", 32'(ign_cnt - ign_base), 2);
    chk("t2_enter_empty_vld", 32'(vld_cnt - vld_base), 0);

    // held handshake; presses during the wait are dropped
    num_ready = 1'b0;
    press(4'd9);
    press(4'hB);
    ign_base = ign_cnt;
    press(4'd1); press(4'hA);
    repeat (6) tick();
    chk("t3_valid_held", 32'(num_valid), 1);
    chk("t3_bcd", 32'(num_bcd), 32'h009);
    chk("t3_bin", 32'(num_bin), 9);
    chk("t3_dig", 32'(digitos), 1);
    chk("t3_ign", 32'(ign_cnt - ign_base), 2);
    num_ready = 1'b1;
    tick();
    chk("t3_rel_valid", 32'(num_valid), 0);
    chk("t3_rel_bcd", 32'(num_bcd), 0);
    chk("t3_rel_dig", 32'(digitos), 0);

    // long hold, then reset while still held
    codigo = 4'd5;
    boton_sal = 1'b1;
    repeat (200) tick();
    chk("t4_hold_dig", 32'(digitos), 1);
    chk("t4_hold_bcd", 32'(num_bcd), 32'h005);
    rst_n = 1'b0;
    tick();
    chk("t4_rst_dig", 32'(digitos), 0);
    chk("t4_rst_bcd", 32'(num_bcd), 0);
    rst_n = 1'b1;
    repeat (10) tick();
    chk("t4_held_after_rst", 32'(digitos), 0);
    boton_sal = 1'b0;
    repeat (2) tick();
    chk("t4_released", 32'(digitos), 0);
    press(4'd5);
    chk("t4_repress", 32'(digitos), 1);
    press(4'hA);

    // leading zeros
    num_ready = 1'b1;
    vld_base = vld_cnt;
    press(4'd0); press(4'd0); press(4'd7);
    chk("t5_bcd", 32'(num_bcd), 32'h007);
    chk("t5_bin", 32'(num_bin), 7);
    chk("t5_dig", 32'(digitos), 3);
    press(4'hB);
    chk("t5_vld_cycles", 32'(vld_cnt - vld_base), 1);
    chk("t5_cap_bin", 32'(cap_bin), 7);
    chk("t5_cap_dig", 32'(cap_dig), 3);

    // unused codes C..F
    press(4'd4);
    ign_base = ign_cnt; vld_base = vld_cnt;
    for (int c = 12; c < 16; c++) press(4'(c));
    chk("t6_ign", 32'(ign_cnt - ign_base), 4);
    chk("t6_bcd", 32'(num_bcd), 32'h004);
    chk("t6_bin", 32'(num_bin), 4);
    chk("t6_dig", 32'(digitos), 1);
    chk("t6_vld", 32'(vld_cnt - vld_base), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
